// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter. tx_uart falls two edges after a push into an idle, empty block.
// tx_ready drops only while the FIFO is full. The parity bit is built only with `UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_byte,
  input  logic                          tx_valid,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          tx_ready,
  output logic                          tx_uart,
  output logic                          tx_done,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int IW   = $clog2(DATA_BITS);
`ifdef UART_TX_PARITY_EN
  localparam int EW   = DATA_BITS + 1;
`else
  localparam int EW   = DATA_BITS;
`endif

  localparam logic [CW-1:0]   CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0]   DATA_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0]   STOP_LAST  = IW'(STOP_BITS - 1);
  localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(FIFO_DEPTH);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $fatal(1, "uart_tx_fifo: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [EW-1:0]        wr_entry;
  logic [EW-1:0]        head;
  logic                 push;
  logic                 pop;

  state_t               state;
  logic [CW-1:0]        bit_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_dat;
  logic                 bit_end;
  logic                 stop_end;
  logic                 line_bit;
`ifdef UART_TX_PARITY_EN
  logic                 par_bit;
`endif

  // Ready depends on the count alone, so a full FIFO never passes a word through on the pop cycle.
  assign tx_ready = !rst && (fifo_count != FULL_COUNT);
  assign push     = tx_valid && tx_ready;

`ifdef UART_TX_PARITY_EN
  assign wr_entry = {parity_odd, tx_byte};
`else
  assign wr_entry = tx_byte;
`endif
  assign head = mem[rd_ptr];

  assign bit_end  = (bit_cnt == CNT_LAST);
  assign stop_end = (state == S_STOP) && bit_end && (bit_idx == STOP_LAST);
  assign pop      = (fifo_count != '0) && ((state == S_IDLE) || stop_end);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        fifo_count <= fifo_count + CNTW'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CNTW'(1);
      end
    end
  end

  always_comb begin
    line_bit = 1'b1;
    case (state)
      S_START:  line_bit = 1'b0;
      S_DATA:   line_bit = shift_dat[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_bit = par_bit;
`endif
      default:  line_bit = 1'b1;
    endcase
  end

  // The line is the state decode delayed one edge; the FSM runs a cycle ahead so reloads add no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_dat <= '0;
      tx_uart   <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      tx_uart <= line_bit;
      tx_busy <= (state != S_IDLE);
      tx_done <= 1'b0;
      bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);

      case (state)
        S_IDLE: begin
          bit_cnt <= '0;
          if (pop) begin
            shift_dat <= head[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
            par_bit   <= head[DATA_BITS] ? ~^head[DATA_BITS-1:0] : ^head[DATA_BITS-1:0];
`endif
            state     <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            shift_dat <= shift_dat >> 1;
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= S_PARITY;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              tx_done <= 1'b1;
              if (pop) begin
                shift_dat <= head[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
                par_bit   <= head[DATA_BITS] ? ~^head[DATA_BITS-1:0] : ^head[DATA_BITS-1:0];
`endif
                state     <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=4: an 8-bit/1-stop instance and a 7-bit/2-stop instance.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = 4 * (10 + PB);

  logic       clk;
  logic       rst;
  logic [7:0] d8_byte;
  logic       d8_valid;
  logic       d8_ready, d8_uart, d8_done, d8_busy;
  logic [2:0] d8_count;
`ifdef UART_TX_PARITY_EN
  logic       d8_odd;
`endif
  logic [6:0] d7_byte;
  logic       d7_valid;
  logic       d7_ready, d7_uart, d7_done, d7_busy;
  logic [2:0] d7_count;

  int vectors;
  int miscompares;
  int cyc;

  int         done_q[$];
  logic [8:0] rx_q[$];
  logic       rx_active;
  int         rx_phase;
  logic [7:0] rx_sh;

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .tx_byte(d8_byte), .tx_valid(d8_valid),
`ifdef UART_TX_PARITY_EN
    .parity_odd(d8_odd),
`endif
    .tx_ready(d8_ready), .tx_uart(d8_uart), .tx_done(d8_done), .tx_busy(d8_busy),
    .fifo_count(d8_count)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut7 (
    .clk(clk), .rst(rst), .tx_byte(d7_byte), .tx_valid(d7_valid),
`ifdef UART_TX_PARITY_EN
    .parity_odd(1'b0),
`endif
    .tx_ready(d7_ready), .tx_uart(d7_uart), .tx_done(d7_done), .tx_busy(d7_busy),
    .fifo_count(d7_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-bit receiver on the 8-bit line plus a log of tx_done cycles.
  always @(negedge clk) begin
    if (rst) begin
      rx_active <= 1'b0;
      rx_phase  <= 0;
    end else if (!rx_active) begin
      if (d8_uart == 1'b0) begin
        rx_active <= 1'b1;
        rx_phase  <= 1;
      end
    end else begin
      rx_phase <= rx_phase + 1;
      if ((rx_phase % 4) == 2 && (rx_phase / 4) >= 1 && (rx_phase / 4) <= 8)
        rx_sh[rx_phase/4 - 1] <= d8_uart;
      if (rx_phase == 4 * (9 + PB) + 2) begin
        rx_q.push_back({d8_uart, rx_sh});
        rx_active <= 1'b0;
      end
    end
    if (d8_done === 1'b1) done_q.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic fbit(input logic [8:0] data, input int nbits, input logic par, input int k);
    int b;
    b = k / 4;
    if (b == 0) return 1'b0;
    if (b <= nbits) return data[b-1];
    if (PB == 1 && b == nbits + 1) return par;
    return 1'b1;
  endfunction

  // One isolated frame on the 8-bit instance, checked cycle by cycle.
  task automatic check_frame8(input logic [7:0] data, input logic odd, input logic exp_par, input string tag);
    d8_byte  = data;
    d8_valid = 1'b1;
`ifdef UART_TX_PARITY_EN
    d8_odd   = odd;
`else
    if (odd) d8_byte = data;
`endif
    chk({tag, "_ready"}, d8_ready, 1'b1);
    tick();
    d8_valid = 1'b0;
    chk({tag, "_count_after_push"}, d8_count, 3'd1);
    tick();
    chk({tag, "_still_idle_at_push+1"}, d8_uart, 1'b1);
    chk({tag, "_count_after_pop"}, d8_count, 3'd0);
    for (int k = 0; k < FL; k++) begin
      tick();
      chk($sformatf("%s_line_k%0d", tag, k), d8_uart, fbit({1'b0, data}, 8, exp_par, k));
      chk($sformatf("%s_done_k%0d", tag, k), d8_done, (k == FL - 1) ? 1'b1 : 1'b0);
      chk($sformatf("%s_busy_k%0d", tag, k), d8_busy, 1'b1);
    end
    tick();
    chk({tag, "_idle_line"}, d8_uart, 1'b1);
    chk({tag, "_idle_busy"}, d8_busy, 1'b0);
    chk({tag, "_idle_done"}, d8_done, 1'b0);
  endtask

  initial begin
    logic [7:0] w [6];
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    w           = '{8'h5A, 8'hC3, 8'h01, 8'hFE, 8'h80, 8'h7E};
    rst      = 1'b1;
    d8_byte  = '0;
    d8_valid = 1'b0;
`ifdef UART_TX_PARITY_EN
    d8_odd   = 1'b0;
`endif
    d7_byte  = '0;
    d7_valid = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_line", d8_uart, 1'b1);
    chk("rst_done", d8_done, 1'b0);
    chk("rst_busy", d8_busy, 1'b0);
    chk("rst_count", d8_count, 3'd0);
    chk("rst_ready", d8_ready, 1'b0);
    chk("rst_ready7", d7_ready, 1'b0);
    chk("rst_line7", d7_uart, 1'b1);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", d8_ready, 1'b1);
    tick();

    // Single frame 0xA5: 0, 1,0,1,0,0,1,0,1, [parity], 1
    check_frame8(8'hA5, 1'b0, 1'b0, "t1_a5");

    // Six back-to-back words; sixth held valid while full
    done_q.delete();
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      d8_byte  = w[i];
      d8_valid = 1'b1;
      chk($sformatf("t2_ready_w%0d", i), d8_ready, 1'b1);
      tick();
    end
    chk("t2_count_full", d8_count, 3'd4);
    chk("t2_ready_full", d8_ready, 1'b0);
    d8_byte = w[5];
    for (int g = 0; g < 200 && d8_count == 3'd4; g++) tick();
    chk("t6_count_drop", d8_count, 3'd3);
    chk("t6_ready_after_drop", d8_ready, 1'b1);
    tick();
    d8_valid = 1'b0;
    chk("t6_push_next_cycle", d8_count, 3'd4);
    for (int g = 0; g < 600 && done_q.size() < 6; g++) tick();
    chk("t2_done_pulses", done_q.size(), 6);
    for (int i = 1; i < 6; i++)
      chk($sformatf("t2_done_gap%0d", i),
          (i < done_q.size()) ? done_q[i] - done_q[i-1] : 0, FL);
    chk("t2_rx_words", rx_q.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t2_rx_word%0d", i), (i < rx_q.size()) ? rx_q[i] : 9'h0, {1'b1, w[i]});
    chk("t2_count_empty", d8_count, 3'd0);

`ifdef UART_TX_PARITY_EN
    // Parity frames: even(03)=0, even(07)=1, odd(07)=0
    check_frame8(8'h03, 1'b0, 1'b0, "t3_03_even");
    check_frame8(8'h07, 1'b0, 1'b1, "t3_07_even");
    check_frame8(8'h07, 1'b1, 1'b0, "t3_07_odd");
`endif

    // 7 data bits, 2 stop bits: 0x41 -> 0, 1,0,0,0,0,0,1, [parity 0], 1, 1
    d7_byte  = 7'h41;
    d7_valid = 1'b1;
    chk("t4_ready", d7_ready, 1'b1);
    tick();
    d7_valid = 1'b0;
    tick();
    chk("t4_still_idle", d7_uart, 1'b1);
    for (int k = 0; k < FL; k++) begin
      tick();
      chk($sformatf("t4_line_k%0d", k), d7_uart, fbit({2'b00, 7'h41}, 7, 1'b0, k));
      chk($sformatf("t4_done_k%0d", k), d7_done, (k == FL - 1) ? 1'b1 : 1'b0);
    end
    tick();
    chk("t4_idle_busy", d7_busy, 1'b0);

    // Reset in the middle of DATA with three words queued
    done_q.delete();
    rx_q.delete();
    d8_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d8_byte = 8'h11 * i[7:0];
      tick();
    end
    d8_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t5_queued", d8_count, 3'd3);
    chk("t5_line_low_in_data", d8_uart, 1'b0);
    chk("t5_busy_in_data", d8_busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("t5_rst_line", d8_uart, 1'b1);
    chk("t5_rst_count", d8_count, 3'd0);
    chk("t5_rst_ready", d8_ready, 1'b0);
    chk("t5_rst_busy", d8_busy, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    chk("t5_no_done", done_q.size(), 0);
    chk("t5_no_frames", rx_q.size(), 0);
    chk("t5_line_idle", d8_uart, 1'b1);
    check_frame8(8'h3C, 1'b0, 1'b0, "t5_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
